// File: rtl/usb_rst_sequencer_if.sv
// Avalon-MM register bus between the Nios II fabric and the USB reset sequencer.
interface usb_rst_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/usb_rst_sequencer.sv
// Timed active-low reset generator for the USB host chip: programmable pulse and
// settle phases, software/hardware request merging, optional completion interrupt.
module usb_rst_sequencer #(
    parameter logic [15:0] ASSERT_DEFAULT = 16'd1000,
    parameter logic [15:0] SETTLE_DEFAULT = 16'd5000
) (
    input  logic               clk,
    input  logic               reset_n,
    usb_rst_sequencer_if.slave bus,
    input  logic               hw_req_i,
    output logic               usb_rst_n_o,
    output logic               irq_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam logic [15:0] ASSERT_LOAD_DEFAULT = (ASSERT_DEFAULT == 16'd0) ? 16'd1 : ASSERT_DEFAULT;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] settle_cap_q, settle_cap_d;
    logic [15:0] assert_cyc_q, assert_cyc_d;
    logic [15:0] settle_cyc_q, settle_cyc_d;
    logic        force_q, force_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        pending_q, pending_d;
    logic        usb_rst_n_q, usb_rst_n_d;
    logic        irq_q, irq_d;
    logic        wr_en, req, finish;
    logic [15:0] assert_load;
    logic        unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign req          = (wr_en & (bus.address == 2'd0) & bus.writedata[0]) | hw_req_i;
    assign assert_load  = (assert_cyc_q == 16'd0) ? 16'd1 : assert_cyc_q;
    assign unused_wdata = ^bus.writedata[31:16];

    always_comb begin
        assert_cyc_d = assert_cyc_q;
        settle_cyc_d = settle_cyc_q;
        force_d      = force_q;
        irq_en_d     = irq_en_q;
        if (wr_en) begin
            case (bus.address)
                2'd0: begin
                    force_d  = bus.writedata[1];
                    irq_en_d = bus.writedata[2];
                end
                2'd1:    assert_cyc_d = bus.writedata[15:0];
                2'd2:    settle_cyc_d = bus.writedata[15:0];
                default: ;
            endcase
        end
    end

    // Timing lengths are latched at sequence start so register writes only affect the next run.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        settle_cap_d = settle_cap_q;
        pending_d    = pending_q;
        finish       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req | pending_q) begin
                    state_d      = ASSERT;
                    cnt_d        = assert_load;
                    settle_cap_d = settle_cyc_q;
                    pending_d    = 1'b0;
                end
            end
            ASSERT: begin
                if (req) pending_d = 1'b1;
                if (cnt_q <= 16'd1) begin
                    if (settle_cap_q == 16'd0) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        state_d = SETTLE;
                        cnt_d   = settle_cap_q;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SETTLE: begin
                if (req) pending_d = 1'b1;
                if (cnt_q <= 16'd1) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completion in the same cycle as a done write-1-clear keeps done set.
    always_comb begin
        done_d = done_q;
        if (wr_en && (bus.address == 2'd3) && bus.writedata[1]) done_d = 1'b0;
        if (finish) done_d = 1'b1;
        irq_d       = done_q & irq_en_q;
        usb_rst_n_d = ~((state_d == ASSERT) | force_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ASSERT;
            cnt_q        <= ASSERT_LOAD_DEFAULT;
            settle_cap_q <= SETTLE_DEFAULT;
            assert_cyc_q <= ASSERT_DEFAULT;
            settle_cyc_q <= SETTLE_DEFAULT;
            force_q      <= 1'b0;
            irq_en_q     <= 1'b0;
            done_q       <= 1'b0;
            pending_q    <= 1'b0;
            usb_rst_n_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            settle_cap_q <= settle_cap_d;
            assert_cyc_q <= assert_cyc_d;
            settle_cyc_q <= settle_cyc_d;
            force_q      <= force_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            usb_rst_n_q  <= usb_rst_n_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0:    bus.readdata = {29'd0, irq_en_q, force_q, 1'b0};
            2'd1:    bus.readdata = {16'd0, assert_cyc_q};
            2'd2:    bus.readdata = {16'd0, settle_cyc_q};
            default: bus.readdata = {27'd0, state_q, pending_q, done_q, (state_q != IDLE)};
        endcase
    end

    assign usb_rst_n_o = usb_rst_n_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Randomized and directed bench for usb_rst_sequencer, checked against a
// timestamp-based model of the reset sequence.
module tb_usb_rst_sequencer;
    localparam int ASSERT_DEF = 1000;
    localparam int SETTLE_DEF = 5000;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic hwReq   = 1'b0;
    logic usbRstN;
    logic irq;
    int   testsRun    = 0;
    int   testsFailed = 0;

    usb_rst_sequencer_if bus ();

    usb_rst_sequencer #(
        .ASSERT_DEFAULT(16'd1000),
        .SETTLE_DEFAULT(16'd5000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .hw_req_i   (hwReq),
        .usb_rst_n_o(usbRstN),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: a sequence is a start edge plus pulse/settle lengths;
    // the phase follows from the number of edges elapsed since the start.
    int edgeCount = 0;
    int mStart, mN, mM, mAssertReg, mSettleReg;
    bit mActive, mPending, mDone, mIrq, mForce, mIrqEn;
    bit modelWr, modelReq, modelW1c, modelFin;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mAssertReg = ASSERT_DEF;
            mSettleReg = SETTLE_DEF;
            mForce     = 1'b0;
            mIrqEn     = 1'b0;
            mDone      = 1'b0;
            mPending   = 1'b0;
            mIrq       = 1'b0;
            mActive    = 1'b1;
            mStart     = edgeCount;
            mN         = ASSERT_DEF;
            mM         = SETTLE_DEF;
        end else begin
            edgeCount++;
            modelWr  = bus.chipselect && !bus.write_n;
            modelReq = (modelWr && bus.address == 2'd0 && bus.writedata[0]) || hwReq;
            modelW1c = modelWr && bus.address == 2'd3 && bus.writedata[1];
            modelFin = mActive && (edgeCount - mStart == mN + mM);
            mIrq     = mDone && mIrqEn;
            if (mActive) begin
                if (modelReq) mPending = 1'b1;
                if (modelFin) mActive = 1'b0;
            end else if (modelReq || mPending) begin
                mActive  = 1'b1;
                mStart   = edgeCount;
                mN       = (mAssertReg == 0) ? 1 : mAssertReg;
                mM       = mSettleReg;
                mPending = 1'b0;
            end
            if (modelW1c) mDone = 1'b0;
            if (modelFin) mDone = 1'b1;
            if (modelWr) begin
                case (bus.address)
                    2'd0: begin
                        mForce = bus.writedata[1];
                        mIrqEn = bus.writedata[2];
                    end
                    2'd1:    mAssertReg = int'(bus.writedata[15:0]);
                    2'd2:    mSettleReg = int'(bus.writedata[15:0]);
                    default: ;
                endcase
            end
        end
    end

    function automatic int expState();
        if (!mActive) return 0;
        return ((edgeCount - mStart) < mN) ? 1 : 2;
    endfunction

    function automatic logic expUsb();
        return !((expState() == 1) || mForce);
    endfunction

    function automatic logic [31:0] expRd(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, mIrqEn, mForce, 1'b0};
            2'd1:    return 32'(mAssertReg);
            2'd2:    return 32'(mSettleReg);
            default: return {27'd0, 2'(expState()), mPending, mDone, mActive};
        endcase
    endfunction

    task automatic driveIdle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd3;
        bus.writedata  = 32'd0;
        hwReq          = 1'b0;
    endtask

    task automatic driveWrite(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        driveWrite(a, d);
        @(negedge clk);
        driveIdle();
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        testsRun += 6;
        if (usbRstN !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset usb_rst_n got %b want 0", usbRstN); end
        if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset irq got %b want 0", irq); end
        if (bus.readdata !== 32'h9) begin testsFailed++; $display("[TB] FAIL reset status got %h want 9", bus.readdata); end
        bus.address = 2'd1; #1;
        if (bus.readdata !== 32'd1000) begin testsFailed++; $display("[TB] FAIL reset assert_cyc got %0d want 1000", bus.readdata); end
        bus.address = 2'd2; #1;
        if (bus.readdata !== 32'd5000) begin testsFailed++; $display("[TB] FAIL reset settle_cyc got %0d want 5000", bus.readdata); end
        bus.address = 2'd0; #1;
        if (bus.readdata !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset ctrl got %h want 0", bus.readdata); end
        bus.address = 2'd3;
        reset_n = 1'b1;
    endtask

    task automatic test_power_on();
        int firstHigh = -1;
        int firstDone = -1;
        int irqSeen   = 0;
        for (int e = 1; e <= ASSERT_DEF + SETTLE_DEF + 20; e++) begin
            @(negedge clk);
            testsRun += 3;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL power_on usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (irq !== mIrq) begin testsFailed++; $display("[TB] FAIL power_on irq e=%0d got %b want %b", e, irq, mIrq); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL power_on readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (firstHigh < 0 && usbRstN === 1'b1) firstHigh = e;
            if (firstDone < 0 && bus.readdata[1] === 1'b1) firstDone = e;
            if (irq !== 1'b0) irqSeen++;
        end
        testsRun += 3;
        if (firstHigh != ASSERT_DEF) begin testsFailed++; $display("[TB] FAIL power_on pulse_len got %0d want %0d", firstHigh, ASSERT_DEF); end
        if (firstDone != ASSERT_DEF + SETTLE_DEF) begin testsFailed++; $display("[TB] FAIL power_on done_edge got %0d want %0d", firstDone, ASSERT_DEF + SETTLE_DEF); end
        if (irqSeen != 0) begin testsFailed++; $display("[TB] FAIL power_on irq_cycles got %0d want 0", irqSeen); end
    endtask

    task automatic test_sw_start();
        int lowCnt = 0, firstLow = -1, doneE = -1, irqE = -1;
        writeReg(2'd1, 32'd3);
        writeReg(2'd2, 32'd2);
        writeReg(2'd3, 32'h2);
        writeReg(2'd0, 32'h4);
        driveWrite(2'd0, 32'h5);
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            testsRun += 3;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL sw_start usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (irq !== mIrq) begin testsFailed++; $display("[TB] FAIL sw_start irq e=%0d got %b want %b", e, irq, mIrq); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL sw_start readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (usbRstN === 1'b0) begin lowCnt++; if (firstLow < 0) firstLow = e; end
            if (doneE < 0 && bus.address == 2'd3 && bus.readdata[1] === 1'b1) doneE = e;
            if (irqE < 0 && irq === 1'b1) irqE = e;
            driveIdle();
        end
        testsRun += 4;
        if (lowCnt != 3 || firstLow != 1) begin testsFailed++; $display("[TB] FAIL sw_start pulse got %0d cycles from e=%0d want 3 from e=1", lowCnt, firstLow); end
        if (doneE != 6) begin testsFailed++; $display("[TB] FAIL sw_start done_edge got %0d want 6", doneE); end
        if (irqE != 7) begin testsFailed++; $display("[TB] FAIL sw_start irq_edge got %0d want 7", irqE); end
        writeReg(2'd3, 32'h2);
        if (bus.readdata[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL sw_start done_w1c got %b want 0", bus.readdata[1]); end
        @(negedge clk);
        testsRun++;
        if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL sw_start irq_clear got %b want 0", irq); end
    endtask

    task automatic test_boundaries();
        int lowCnt = 0, firstLow = -1, doneE = -1;
        writeReg(2'd1, 32'd0);
        writeReg(2'd2, 32'd0);
        writeReg(2'd3, 32'h2);
        writeReg(2'd0, 32'h0);
        driveWrite(2'd0, 32'h1);
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            testsRun += 3;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL boundaries usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (irq !== mIrq) begin testsFailed++; $display("[TB] FAIL boundaries irq e=%0d got %b want %b", e, irq, mIrq); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL boundaries readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (bus.address == 2'd3) begin
                testsRun++;
                if (bus.readdata[4:3] === 2'd2) begin testsFailed++; $display("[TB] FAIL boundaries state e=%0d got 2 want not 2", e); end
                if (doneE < 0 && bus.readdata[1] === 1'b1) doneE = e;
            end
            if (usbRstN === 1'b0) begin lowCnt++; if (firstLow < 0) firstLow = e; end
            driveIdle();
        end
        testsRun += 2;
        if (lowCnt != 1 || firstLow != 1) begin testsFailed++; $display("[TB] FAIL boundaries pulse got %0d cycles from e=%0d want 1 from e=1", lowCnt, firstLow); end
        if (doneE != 2) begin testsFailed++; $display("[TB] FAIL boundaries done_edge got %0d want 2", doneE); end
    endtask

    task automatic test_arbitration();
        int falls = 0, secondFall = -1, doneE = -1, pendSeen = 0;
        logic prev = 1'b1;
        writeReg(2'd1, 32'd2);
        writeReg(2'd2, 32'd2);
        writeReg(2'd3, 32'h2);
        driveWrite(2'd0, 32'h1);
        hwReq = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            testsRun += 3;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL arb_same usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL arb_same readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (bus.address == 2'd3 && bus.readdata[2] !== 1'b0) begin testsFailed++; $display("[TB] FAIL arb_same pending e=%0d got %b want 0", e, bus.readdata[2]); end
            if (prev === 1'b1 && usbRstN === 1'b0) falls++;
            prev = usbRstN;
            driveIdle();
        end
        testsRun++;
        if (falls != 1) begin testsFailed++; $display("[TB] FAIL arb_same sequences got %0d want 1", falls); end

        writeReg(2'd1, 32'd5);
        writeReg(2'd2, 32'd3);
        writeReg(2'd3, 32'h2);
        falls = 0;
        prev  = usbRstN;
        hwReq = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(negedge clk);
            testsRun += 2;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL arb_pend usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL arb_pend readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (prev === 1'b1 && usbRstN === 1'b0) begin falls++; if (falls == 2) secondFall = e; end
            prev = usbRstN;
            if (bus.readdata[2] === 1'b1) pendSeen++;
            if (doneE < 0 && bus.readdata[1] === 1'b1) doneE = e;
            driveIdle();
            if (e >= 2 && e <= 4) hwReq = 1'b1;
        end
        testsRun += 4;
        if (pendSeen == 0) begin testsFailed++; $display("[TB] FAIL arb_pend pending got 0 cycles want >0"); end
        if (falls != 2) begin testsFailed++; $display("[TB] FAIL arb_pend sequences got %0d want 2", falls); end
        if (doneE != 9) begin testsFailed++; $display("[TB] FAIL arb_pend done_edge got %0d want 9", doneE); end
        if (secondFall != doneE + 1) begin testsFailed++; $display("[TB] FAIL arb_pend restart_edge got %0d want %0d", secondFall, doneE + 1); end
    endtask

    task automatic test_force_retime();
        int firstHigh = -1, doneE = -1, secondLow = 0;
        writeReg(2'd1, 32'd4);
        writeReg(2'd2, 32'd6);
        writeReg(2'd3, 32'h2);
        driveWrite(2'd0, 32'h1);
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            testsRun += 3;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL force usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (irq !== mIrq) begin testsFailed++; $display("[TB] FAIL force irq e=%0d got %b want %b", e, irq, mIrq); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL force readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (e == 7) begin
                testsRun++;
                if (usbRstN !== 1'b0) begin testsFailed++; $display("[TB] FAIL force forced_low got %b want 0", usbRstN); end
            end
            if (firstHigh < 0 && usbRstN === 1'b1) firstHigh = e;
            if (doneE < 0 && bus.address == 2'd3 && bus.readdata[1] === 1'b1) doneE = e;
            if (e >= 13 && usbRstN === 1'b0) secondLow++;
            driveIdle();
            if (e == 2)  driveWrite(2'd1, 32'd7);
            if (e == 5)  driveWrite(2'd0, 32'h2);
            if (e == 8)  driveWrite(2'd0, 32'h0);
            if (e == 12) driveWrite(2'd0, 32'h1);
        end
        testsRun += 3;
        if (firstHigh != 5) begin testsFailed++; $display("[TB] FAIL force first_pulse_end got %0d want 5", firstHigh); end
        if (doneE != 11) begin testsFailed++; $display("[TB] FAIL force done_edge got %0d want 11", doneE); end
        if (secondLow != 7) begin testsFailed++; $display("[TB] FAIL force second_pulse got %0d want 7", secondLow); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        bit idleSeen = 1'b0;
        for (int e = 1; e <= 400; e++) begin
            @(negedge clk);
            testsRun += 3;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL random usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (irq !== mIrq) begin testsFailed++; $display("[TB] FAIL random irq e=%0d got %b want %b", e, irq, mIrq); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL random readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            driveIdle();
            bus.address = 2'($urandom_range(0, 3));
            hwReq = ($urandom_range(0, 6) == 0);
            case ($urandom_range(0, 9))
                0: begin d = $urandom; d[1] = ($urandom_range(0, 4) == 0); driveWrite(2'd0, d); end
                1: begin d = $urandom; d[15:0] = 16'($urandom_range(0, 6)); driveWrite(2'd1, d); end
                2: begin d = $urandom; d[15:0] = 16'($urandom_range(0, 6)); driveWrite(2'd2, d); end
                3: driveWrite(2'd3, $urandom);
                default: ;
            endcase
        end
        @(negedge clk);
        driveIdle();
        writeReg(2'd0, 32'h0);
        for (int i = 0; i < 200 && !idleSeen; i++) begin
            @(negedge clk);
            if (bus.readdata[0] === 1'b0 && bus.readdata[2] === 1'b0) idleSeen = 1'b1;
        end
        testsRun += 2;
        if (!idleSeen) begin testsFailed++; $display("[TB] FAIL random idle_timeout got busy want idle"); end
        if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL random final_status got %h want %h", bus.readdata, expRd(bus.address)); end
    endtask

    task automatic test_reset_mid_settle();
        int firstHigh = -1;
        writeReg(2'd1, 32'd1);
        writeReg(2'd2, 32'd0);
        writeReg(2'd0, 32'h1);
        repeat (3) @(negedge clk);
        writeReg(2'd1, 32'd2);
        writeReg(2'd2, 32'd20);
        driveWrite(2'd0, 32'h1);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            testsRun += 2;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL mid_reset usb_rst_n e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL mid_reset readdata e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (e == 8) begin
                testsRun++;
                if (bus.readdata !== 32'd23) begin testsFailed++; $display("[TB] FAIL mid_reset pre_status got %h want 17", bus.readdata); end
            end
            driveIdle();
            if (e == 4) hwReq = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1;
        testsRun += 3;
        if (usbRstN !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset async_usb got %b want 0", usbRstN); end
        if (bus.readdata !== 32'h9) begin testsFailed++; $display("[TB] FAIL mid_reset status got %h want 9", bus.readdata); end
        if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_reset irq got %b want 0", irq); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= ASSERT_DEF + 10; e++) begin
            @(negedge clk);
            testsRun += 2;
            if (usbRstN !== expUsb()) begin testsFailed++; $display("[TB] FAIL mid_reset rerun_usb e=%0d got %b want %b", e, usbRstN, expUsb()); end
            if (bus.readdata !== expRd(bus.address)) begin testsFailed++; $display("[TB] FAIL mid_reset rerun_rd e=%0d got %h want %h", e, bus.readdata, expRd(bus.address)); end
            if (firstHigh < 0 && usbRstN === 1'b1) firstHigh = e;
        end
        testsRun++;
        if (firstHigh != ASSERT_DEF) begin testsFailed++; $display("[TB] FAIL mid_reset rerun_pulse got %0d want %0d", firstHigh, ASSERT_DEF); end
    endtask

    initial begin
        driveIdle();
        test_reset();
        test_power_on();
        test_sw_start();
        test_boundaries();
        test_arbitration();
        test_force_retime();
        test_random();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
